// File: rtl/xmode_decoder_if.sv
// Sample bus from the pattern datapath into the Xmode decoder.
interface xmode_decoder_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              in_vld;
    logic [ADDR_W-1:0] in_addr;

    modport master (output in_vld, in_addr);
    modport slave  (input  in_vld, in_addr);
endinterface

// File: rtl/xmode_decoder.sv
// Recovers the Xmode step code from an observed address stream, locks on a
// stable step and flags any later departure as a sticky fault.
module xmode_decoder #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned RUN_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    xmode_decoder_if.slave    smp,
    output logic [1:0]        xmode_out,
    output logic              lock,
    output logic              err,
    output logic [RUN_W-1:0]  run_len,
    output logic [ADDR_W-1:0] last_addr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIMED = 3'd1,
        TRACK  = 3'd2,
        LOCKED = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t            state;
    logic [1:0]        cand;
    logic [ADDR_W-1:0] diff_c;
    logic [1:0]        code_c;
    logic              legal_c;
    logic [RUN_W-1:0]  run_inc_c;
    logic              lock_hit_c;

    // Step classification and saturating run increment
    always_comb begin
        diff_c     = smp.in_addr - last_addr;
        code_c     = 2'b00;
        legal_c    = 1'b1;
        case (diff_c)
            ADDR_W'(0): code_c = 2'b00;
            ADDR_W'(1): code_c = 2'b01;
            ADDR_W'(4): code_c = 2'b10;
            ADDR_W'(8): code_c = 2'b11;
            default:    legal_c = 1'b0;
        endcase
        run_inc_c  = (run_len == {RUN_W{1'b1}}) ? run_len : run_len + RUN_W'(1);
        lock_hit_c = (run_inc_c >= RUN_W'(LOCK_CNT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= IDLE;
            cand      <= 2'b00;
            xmode_out <= 2'b00;
            lock      <= 1'b0;
            err       <= 1'b0;
            run_len   <= '0;
            last_addr <= '0;
        end else if (smp.in_vld) begin
            // FAULT is absorbing; every other state accepts the sample address
            if (state != FAULT) begin
                last_addr <= smp.in_addr;
            end
            case (state)
                IDLE: begin
                    state <= PRIMED;
                end
                PRIMED: begin
                    if (!legal_c) begin
                        state <= FAULT;
                        err   <= 1'b1;
                    end else begin
                        cand    <= code_c;
                        run_len <= RUN_W'(1);
                        if (LOCK_CNT == 1) begin
                            state     <= LOCKED;
                            lock      <= 1'b1;
                            xmode_out <= code_c;
                        end else begin
                            state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (!legal_c) begin
                        state <= FAULT;
                        err   <= 1'b1;
                    end else if (code_c == cand) begin
                        run_len <= run_inc_c;
                        if (lock_hit_c) begin
                            state     <= LOCKED;
                            lock      <= 1'b1;
                            xmode_out <= cand;
                        end
                    end else begin
                        cand    <= code_c;
                        run_len <= RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (legal_c && (code_c == xmode_out)) begin
                        run_len <= run_inc_c;
                    end else begin
                        state <= FAULT;
                        err   <= 1'b1;
                        lock  <= 1'b0;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xmode_decoder.sv
// Random and directed stimulus for xmode_decoder, checked against a model that
// replays the accepted-sample history after every edge.
module tb_xmode_decoder;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned LOCK_CNT = 3;
    localparam int unsigned RUN_W    = 8;
    localparam int unsigned AMOD     = 1 << ADDR_W;
    localparam int unsigned RUN_MAX  = (1 << RUN_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic [1:0]        xmode_out;
    logic              lock;
    logic              err;
    logic [RUN_W-1:0]  run_len;
    logic [ADDR_W-1:0] last_addr;

    int checks = 0;
    int errors = 0;

    xmode_decoder_if #(.ADDR_W(ADDR_W)) smp ();

    xmode_decoder #(
        .ADDR_W  (ADDR_W),
        .LOCK_CNT(LOCK_CNT),
        .RUN_W   (RUN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .smp      (smp),
        .xmode_out(xmode_out),
        .lock     (lock),
        .err      (err),
        .run_len  (run_len),
        .last_addr(last_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: accepted samples since the last reset/clr, plus derived outputs
    int unsigned hist[$];
    int unsigned m_xm, m_lk, m_er, m_rl, m_la;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_code(input int unsigned d);
        if (d == 0) return 0;
        if (d == 1) return 1;
        if (d == 4) return 2;
        if (d == 8) return 3;
        return -1;
    endfunction

    // Replays the whole history: first illegal step or post-lock mismatch ends it
    task automatic model_eval();
        bit          locked;
        int          cand;
        int unsigned run;
        int unsigned d;
        int          c;
        locked = 1'b0;
        cand   = 0;
        run    = 0;
        m_xm   = 0;
        m_lk   = 0;
        m_er   = 0;
        m_la   = (hist.size() > 0) ? hist[hist.size()-1] : 0;
        for (int i = 1; i < hist.size(); i++) begin
            d = (hist[i] + AMOD - hist[i-1]) % AMOD;
            c = step_code(d);
            if (c < 0) begin
                m_er = 1;
                m_lk = 0;
                break;
            end
            if (locked) begin
                if (c == int'(m_xm)) begin
                    run = (run < RUN_MAX) ? run + 1 : RUN_MAX;
                end else begin
                    m_er = 1;
                    m_lk = 0;
                    break;
                end
            end else begin
                if (i > 1 && c == cand) run++;
                else begin
                    cand = c;
                    run  = 1;
                end
                if (run >= LOCK_CNT) begin
                    locked = 1'b1;
                    m_lk   = 1;
                    m_xm   = c;
                end
            end
        end
        m_rl = run;
    endtask

    // One clock: apply inputs, update model, compare all outputs 1 time unit after the edge
    task automatic cyc(input bit vld, input int unsigned addr, input bit c, input bit r);
        smp.in_vld  = vld;
        smp.in_addr = ADDR_W'(addr);
        clr         = c;
        rst_n       = r;
        @(posedge clk);
        #1;
        if (!r || c) hist.delete();
        else if (vld && m_er == 0) hist.push_back(addr % AMOD);
        model_eval();
        check("xmode_out", 32'(xmode_out), m_xm);
        check("lock",      32'(lock),      m_lk);
        check("err",       32'(err),       m_er);
        check("run_len",   32'(run_len),   m_rl);
        check("last_addr", 32'(last_addr), m_la);
    endtask

    task automatic sample(input int unsigned addr);
        cyc(1'b1, addr, 1'b0, 1'b1);
    endtask

    task automatic gap();
        cyc(1'b0, $urandom_range(0, AMOD - 1), 1'b0, 1'b1);
    endtask

    task automatic do_clr();
        cyc(1'b0, 0, 1'b1, 1'b1);
    endtask

    int unsigned addr;
    int unsigned pref;
    int unsigned r;
    int unsigned legal_steps[4] = '{0, 1, 4, 8};

    initial begin
        smp.in_vld  = 1'b0;
        smp.in_addr = '0;
        clr         = 1'b0;
        rst_n       = 1'b0;
        m_er        = 0;
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        check("reset_run_len", 32'(run_len), 32'd0);

        // Step 1 lock
        sample(12'h010); sample(12'h011); sample(12'h012); sample(12'h013);
        check("tp1_lock", 32'(lock), 32'd1);
        check("tp1_xmode", 32'(xmode_out), 32'd1);
        check("tp1_run", 32'(run_len), 32'd3);

        // Wrap-around on step 8
        do_clr();
        sample(12'hFF0); sample(12'hFF8); sample(12'h000); sample(12'h008);
        check("wrap_xmode", 32'(xmode_out), 32'd3);
        sample(12'h010);
        check("wrap_run", 32'(run_len), 32'd4);

        // Illegal step then frozen FAULT
        do_clr();
        sample(12'h100); sample(12'h103);
        check("ill_err", 32'(err), 32'd1);
        sample(12'h104);
        check("ill_last", 32'(last_addr), 32'h103);

        // Candidate change with gaps
        do_clr();
        sample(12'h000); gap(); sample(12'h004); gap(); gap();
        sample(12'h005);
        check("cand_run", 32'(run_len), 32'd1);
        gap(); sample(12'h006); sample(12'h007);
        check("cand_lock", 32'(lock), 32'd1);
        check("cand_xmode", 32'(xmode_out), 32'd1);

        // Locked mismatch
        do_clr();
        sample(12'h000); sample(12'h004); sample(12'h008); sample(12'h00C);
        sample(12'h00D);
        check("lmm_err", 32'(err), 32'd1);
        check("lmm_xmode", 32'(xmode_out), 32'd2);

        // clr beats in_vld, then step-0 lock and saturation
        cyc(1'b1, 12'h055, 1'b1, 1'b1);
        check("clr_last", 32'(last_addr), 32'd0);
        for (int i = 0; i < 300; i++) sample(12'h020);
        check("sat_run", 32'(run_len), 32'd255);
        check("sat_lock", 32'(lock), 32'd1);

        // Reset mid-lock
        cyc(1'b1, 12'h020, 1'b0, 1'b0);
        check("rst_lock", 32'(lock), 32'd0);

        // Random stream with gaps, preferred steps, illegal steps, clr and reset
        addr = $urandom_range(0, AMOD - 1);
        pref = legal_steps[$urandom_range(0, 3)];
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            if (r < 3) begin
                do_clr();
            end else if (r < 4) begin
                cyc(1'b1, addr, 1'b0, 1'b0);
            end else if (r < 40) begin
                gap();
            end else begin
                if (r < 44) pref = legal_steps[$urandom_range(0, 3)];
                if (r < 46) addr = (addr + $urandom_range(0, AMOD - 1)) % AMOD;
                else if (r < 52) addr = (addr + legal_steps[$urandom_range(0, 3)]) % AMOD;
                else addr = (addr + pref) % AMOD;
                sample(addr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
